// File: rtl/ip_packet_rx.sv
// Receive-side IPv4 deframer: parses a fixed 34-byte frame from the MAC, filters on
// destination MAC/IP, version byte and header checksum, and presents accepted packets to the accelerator.
module ip_packet_rx #(
  parameter int AXI_S_DATA_WIDTH = 8,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int ACCEL_DATA_WIDTH = 10,
  parameter bit ACCEPT_BROADCAST = 1'b1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
  input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
  input  logic                        MAC_DATA_VALID,
  input  logic                        MAC_DATA_LAST,
  output logic                        MAC_DATA_READY,
  output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0] RECEIVED_MESSAGE,
  output logic                        MESSAGE_VALID,
  input  logic                        MESSAGE_READY,
  output logic                        PACKET_DROPPED
);

  typedef enum logic [2:0] {
    S_IDLE, S_ETH_HDR, S_IP_HDR, S_PAYLOAD, S_HOLD, S_DISCARD
  } state_t;

  state_t r_state, w_state_nxt;

  logic [5:0]                r_cnt;
  logic                      r_own_bad, r_bcast_bad, r_ver_bad, r_ip_bad, r_csum_bad;
  logic [19:0]               r_acc;
  logic [7:0]                r_hi;
  logic [1:0]                r_b32;
  logic [MAC_ADDR_WIDTH-1:0] r_src_mac;
  logic [IP_ADDR_WIDTH-1:0]  r_src_ip;

  logic        w_beat, w_parse, w_load, w_drop, w_all_ok;
  logic [7:0]  w_mac_byte, w_ip_byte;
  logic [19:0] w_acc_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  assign MAC_DATA_READY = (r_state != S_HOLD);
  assign w_beat  = MAC_DATA_VALID && MAC_DATA_READY;
  assign w_parse = w_beat && (r_state != S_DISCARD);

  always_comb begin
    w_mac_byte = ACCELERATOR_MAC_ADDRESS[7:0];
    case (r_cnt[2:0])
      3'd0:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[47:40];
      3'd1:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[39:32];
      3'd2:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[31:24];
      3'd3:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[23:16];
      3'd4:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[15:8];
      default: w_mac_byte = ACCELERATOR_MAC_ADDRESS[7:0];
    endcase
  end

  // Destination IP occupies bytes 28..31, so the low two count bits select the octet.
  always_comb begin
    w_ip_byte = ACCELERATOR_IP_ADDRESS[7:0];
    case (r_cnt[1:0])
      2'd0:    w_ip_byte = ACCELERATOR_IP_ADDRESS[31:24];
      2'd1:    w_ip_byte = ACCELERATOR_IP_ADDRESS[23:16];
      2'd2:    w_ip_byte = ACCELERATOR_IP_ADDRESS[15:8];
      default: w_ip_byte = ACCELERATOR_IP_ADDRESS[7:0];
    endcase
  end

  assign w_acc_sum = r_acc + {4'd0, r_hi, MAC_DATA_IN};
  assign w_fold1   = {1'b0, w_acc_sum[15:0]} + {13'd0, w_acc_sum[19:16]};
  assign w_fold2   = w_fold1[15:0] + {15'd0, w_fold1[16]};

  assign w_all_ok = !(r_own_bad && (r_bcast_bad || !ACCEPT_BROADCAST)) &&
                    !r_ver_bad && !r_ip_bad && !r_csum_bad;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE, S_ETH_HDR, S_IP_HDR, S_PAYLOAD: begin
        if (w_beat) begin
          if (r_cnt == 6'd33) begin
            if (!MAC_DATA_LAST) begin
              w_state_nxt = S_DISCARD;
            end else if (w_all_ok) begin
              w_state_nxt = S_HOLD;
              w_load      = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_drop      = 1'b1;
            end
          end else if (MAC_DATA_LAST) begin
            w_state_nxt = S_IDLE;
            w_drop      = 1'b1;
          end else if (r_cnt == 6'd0) begin
            w_state_nxt = S_ETH_HDR;
          end else if (r_cnt == 6'd11) begin
            w_state_nxt = S_IP_HDR;
          end else if (r_cnt == 6'd31) begin
            w_state_nxt = S_PAYLOAD;
          end
        end
      end
      S_DISCARD: begin
        if (w_beat && MAC_DATA_LAST) begin
          w_state_nxt = S_IDLE;
          w_drop      = 1'b1;
        end
      end
      S_HOLD: begin
        if (MESSAGE_READY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter parks at 33 through DISCARD and clears whenever a frame ends.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt       <= 6'd0;
      r_own_bad   <= 1'b0;
      r_bcast_bad <= 1'b0;
      r_ver_bad   <= 1'b0;
      r_ip_bad    <= 1'b0;
      r_csum_bad  <= 1'b0;
    end else begin
      if (w_state_nxt == S_IDLE || w_state_nxt == S_HOLD) r_cnt <= 6'd0;
      else if (w_beat && r_cnt != 6'd33)                   r_cnt <= r_cnt + 6'd1;

      if (w_parse) begin
        if (r_cnt == 6'd0) begin
          r_own_bad   <= (MAC_DATA_IN != w_mac_byte);
          r_bcast_bad <= (MAC_DATA_IN != 8'hFF);
          r_ver_bad   <= 1'b0;
          r_ip_bad    <= 1'b0;
          r_csum_bad  <= 1'b0;
        end else if (r_cnt < 6'd6) begin
          r_own_bad   <= r_own_bad   | (MAC_DATA_IN != w_mac_byte);
          r_bcast_bad <= r_bcast_bad | (MAC_DATA_IN != 8'hFF);
        end
        if (r_cnt == 6'd12)                      r_ver_bad  <= (MAC_DATA_IN != 8'h45);
        if (r_cnt >= 6'd28 && r_cnt <= 6'd31)    r_ip_bad   <= r_ip_bad | (MAC_DATA_IN != w_ip_byte);
        if (r_cnt == 6'd31)                      r_csum_bad <= (w_fold2 != 16'hFFFF);
      end
    end
  end

  // Shadow capture and checksum accumulation; contents only matter within a frame.
  always_ff @(posedge aclk) begin
    if (w_parse) begin
      if (r_cnt == 6'd0) r_acc <= 20'd0;
      if (r_cnt >= 6'd6 && r_cnt <= 6'd11)
        r_src_mac <= {r_src_mac[MAC_ADDR_WIDTH-9:0], MAC_DATA_IN};
      if (r_cnt >= 6'd24 && r_cnt <= 6'd27)
        r_src_ip <= {r_src_ip[IP_ADDR_WIDTH-9:0], MAC_DATA_IN};
      if (r_cnt >= 6'd12 && r_cnt <= 6'd31) begin
        if (!r_cnt[0]) r_hi  <= MAC_DATA_IN;
        else           r_acc <= w_acc_sum;
      end
      if (r_cnt == 6'd32) r_b32 <= MAC_DATA_IN[1:0];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      MESSAGE_VALID      <= 1'b0;
      PACKET_DROPPED     <= 1'b0;
      SENDER_IP_ADDRESS  <= '0;
      SENDER_MAC_ADDRESS <= '0;
      RECEIVED_MESSAGE   <= '0;
    end else begin
      PACKET_DROPPED <= w_drop;
      if (w_load) begin
        MESSAGE_VALID      <= 1'b1;
        SENDER_IP_ADDRESS  <= r_src_ip;
        SENDER_MAC_ADDRESS <= r_src_mac;
        RECEIVED_MESSAGE   <= {r_b32, MAC_DATA_IN};
      end else if (r_state == S_HOLD && MESSAGE_READY) begin
        MESSAGE_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ip_packet_rx.sv
// Bench for ip_packet_rx: directed scenarios followed by randomized frames, checked
// against a frame-level acceptance model; two instances cover both broadcast settings.
module tb_ip_packet_rx;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] own_ip;
  logic [47:0] own_mac;
  logic [7:0]  din;
  logic        vld, last, mrdy;

  logic        rdy0, val0, drp0, rdy1, val1, drp1;
  logic [31:0] sip0, sip1;
  logic [47:0] smac0, smac1;
  logic [9:0]  msg0, msg1;

  int total = 0;
  int bad   = 0;

  logic [7:0] fr [64];
  int         flen;

  always #5 aclk = ~aclk;

  ip_packet_rx #(.ACCEPT_BROADCAST(1'b1)) u0 (
    .aclk(aclk), .areset(areset),
    .ACCELERATOR_IP_ADDRESS(own_ip), .ACCELERATOR_MAC_ADDRESS(own_mac),
    .MAC_DATA_IN(din), .MAC_DATA_VALID(vld), .MAC_DATA_LAST(last), .MAC_DATA_READY(rdy0),
    .SENDER_IP_ADDRESS(sip0), .SENDER_MAC_ADDRESS(smac0), .RECEIVED_MESSAGE(msg0),
    .MESSAGE_VALID(val0), .MESSAGE_READY(mrdy), .PACKET_DROPPED(drp0));

  ip_packet_rx #(.ACCEPT_BROADCAST(1'b0)) u1 (
    .aclk(aclk), .areset(areset),
    .ACCELERATOR_IP_ADDRESS(own_ip), .ACCELERATOR_MAC_ADDRESS(own_mac),
    .MAC_DATA_IN(din), .MAC_DATA_VALID(vld), .MAC_DATA_LAST(last), .MAC_DATA_READY(rdy1),
    .SENDER_IP_ADDRESS(sip1), .SENDER_MAC_ADDRESS(smac1), .RECEIVED_MESSAGE(msg1),
    .MESSAGE_VALID(val1), .MESSAGE_READY(mrdy), .PACKET_DROPPED(drp1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] hdr_sum();
    logic [31:0] s = 0;
    for (int i = 12; i < 32; i += 2) s += {16'd0, fr[i], fr[i+1]};
    while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic finalize();
    fr[22] = 8'h00; fr[23] = 8'h00;
    {fr[22], fr[23]} = ~hdr_sum();
  endtask

  task automatic build(input logic [47:0] dmac, input logic [47:0] smac,
                       input logic [31:0] dip, input logic [31:0] sip, input logic [15:0] pay);
    for (int i = 0; i < 6; i++) begin
      fr[i]   = dmac[47-8*i -: 8];
      fr[6+i] = smac[47-8*i -: 8];
    end
    fr[12] = 8'h45; fr[13] = 8'h00; fr[14] = 8'h00; fr[15] = 8'h16;
    fr[16] = 8'($urandom); fr[17] = 8'($urandom);
    fr[18] = 8'h40; fr[19] = 8'h00; fr[20] = 8'h40; fr[21] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      fr[24+i] = sip[31-8*i -: 8];
      fr[28+i] = dip[31-8*i -: 8];
    end
    fr[32] = pay[15:8]; fr[33] = pay[7:0];
    flen = 34;
    finalize();
  endtask

  // Frame-level acceptance rule for one broadcast setting.
  function automatic bit model_ok(input bit bcast);
    logic [47:0] dm;
    logic [31:0] di;
    bit          mac_ok;
    if (flen != 34) return 1'b0;
    for (int i = 0; i < 6; i++) dm[47-8*i -: 8] = fr[i];
    for (int i = 0; i < 4; i++) di[31-8*i -: 8] = fr[28+i];
    mac_ok = (dm == own_mac) || (bcast && dm == 48'hFFFF_FFFF_FFFF);
    return mac_ok && fr[12] == 8'h45 && di == own_ip && hdr_sum() == 16'hFFFF;
  endfunction

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        vld = 1'b0; din = 8'($urandom);
        @(posedge aclk); #1;
      end
      din = fr[i]; vld = 1'b1; last = (i == flen - 1);
      mrdy = (i == flen - 1) ? 1'b0 : 1'($urandom);
      @(posedge aclk); #1;
      vld = 1'b0; last = 1'b0; mrdy = 1'b0;
      if (i != flen - 1) begin
        chk("mid_valid0", val0, 0); chk("mid_drop0", drp0, 0);
        chk("mid_valid1", val1, 0); chk("mid_drop1", drp1, 0);
      end
    end
  endtask

  task automatic check_result(input int hold);
    bit          e0, e1;
    logic [31:0] esip;
    logic [47:0] esmac;
    logic [9:0]  emsg;
    e0 = model_ok(1'b1);
    e1 = model_ok(1'b0);
    for (int i = 0; i < 6; i++) esmac[47-8*i -: 8] = fr[6+i];
    for (int i = 0; i < 4; i++) esip[31-8*i -: 8] = fr[24+i];
    emsg = {fr[32][1:0], fr[33]};
    chk("valid0", val0, e0); chk("drop0", drp0, !e0);
    chk("valid1", val1, e1); chk("drop1", drp1, !e1);
    if (e0 || e1) begin
      for (int c = 0; c < hold; c++) begin
        if (e0) begin
          chk("hold_valid0", val0, 1); chk("hold_ready0", rdy0, 0);
          chk("sip0", sip0, esip); chk("smac0", smac0, esmac); chk("msg0", msg0, emsg);
        end
        if (e1) begin
          chk("hold_valid1", val1, 1); chk("hold_ready1", rdy1, 0);
          chk("sip1", sip1, esip); chk("smac1", smac1, esmac); chk("msg1", msg1, emsg);
        end
        @(posedge aclk); #1;
      end
      mrdy = 1'b1;
      @(posedge aclk); #1;
      mrdy = 1'b0;
      chk("rel_valid0", val0, 0); chk("rel_ready0", rdy0, 1);
      chk("rel_valid1", val1, 0); chk("rel_ready1", rdy1, 1);
    end else begin
      @(posedge aclk); #1;
    end
    chk("drop_end0", drp0, 0); chk("drop_end1", drp1, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", rdy0, 1); chk("rst_valid", val0, 0); chk("rst_drop", drp0, 0);
    chk("rst_sip", sip0, 0); chk("rst_smac", smac0, 0); chk("rst_msg", msg0, 0);
    chk("rst_valid1", val1, 0); chk("rst_drop1", drp1, 0);
  endtask

  localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_09;
  localparam logic [31:0] SRC_IP  = 32'h0A00_0001;

  initial begin
    int kind;
    areset = 1'b1; vld = 1'b0; last = 1'b0; mrdy = 1'b0; din = 8'h00;
    own_mac = 48'h02_00_00_00_00_01;
    own_ip  = 32'h0A00_0002;
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_vals();
    areset = 1'b0;
    @(posedge aclk); #1;

    // Good frame, long hold, then explicit message value.
    build(own_mac, SRC_MAC, own_ip, SRC_IP, 16'h03A5);
    send_bytes(flen);
    chk("msg_3A5", msg0, 10'h3A5);
    check_result(5);

    // Corrupted checksum byte.
    build(own_mac, SRC_MAC, own_ip, SRC_IP, 16'h0155);
    fr[22] ^= 8'h01;
    send_bytes(flen); check_result(1);

    // Wrong dst IP, wrong dst MAC, broadcast.
    build(own_mac, SRC_MAC, 32'h0A00_0003, SRC_IP, 16'h0222);
    send_bytes(flen); check_result(1);
    build(48'h02_00_00_00_00_02, SRC_MAC, own_ip, SRC_IP, 16'h0333);
    send_bytes(flen); check_result(1);
    build(48'hFFFF_FFFF_FFFF, SRC_MAC, own_ip, SRC_IP, 16'hFC44);
    send_bytes(flen); check_result(2);

    // Runt ending on byte 20, oversize 40-byte frame, then good frame.
    build(own_mac, SRC_MAC, own_ip, SRC_IP, 16'h0111);
    flen = 21;
    send_bytes(flen); check_result(1);
    build(own_mac, SRC_MAC, own_ip, SRC_IP, 16'h0111);
    flen = 40;
    for (int i = 34; i < 40; i++) fr[i] = 8'($urandom);
    send_bytes(flen); check_result(1);
    build(own_mac, SRC_MAC, own_ip, SRC_IP, 16'h02BC);
    send_bytes(flen); check_result(2);

    // Asynchronous reset partway through a frame.
    build(own_mac, SRC_MAC, own_ip, SRC_IP, 16'h0123);
    send_bytes(16);
    areset = 1'b1;
    #1;
    chk_reset_vals();
    @(posedge aclk); #1;
    areset = 1'b0;
    chk_reset_vals();
    build(own_mac, SRC_MAC, own_ip, SRC_IP, 16'h0321);
    send_bytes(flen); check_result(1);

    // Randomized frames against the model.
    for (int n = 0; n < 60; n++) begin
      logic [47:0] dmac;
      logic [31:0] dip;
      own_mac = {16'($urandom), 32'($urandom)};
      own_ip  = 32'($urandom);
      dmac = own_mac; dip = own_ip;
      kind = $urandom_range(0, 9);
      if (kind == 1) dmac ^= 48'd1 << $urandom_range(0, 47);
      if (kind == 2) dmac = 48'hFFFF_FFFF_FFFF;
      if (kind == 3) dip ^= 32'd1 << $urandom_range(0, 31);
      build(dmac, {16'($urandom), 32'($urandom)}, dip, 32'($urandom), 16'($urandom));
      if (kind == 4) fr[$urandom_range(12, 31)] ^= 8'h01 << $urandom_range(0, 7);
      if (kind == 5) begin fr[12] = 8'h46; finalize(); end
      if (kind == 6) flen = $urandom_range(1, 33);
      if (kind == 7) begin
        flen = $urandom_range(35, 45);
        for (int i = 34; i < flen; i++) fr[i] = 8'($urandom);
      end
      send_bytes(flen);
      check_result($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
